// File: rtl/reg_write_arbiter_if.sv
// Signal bundle between the register-file write arbiter and the pipeline,
// the multicycle unit and the decode stage.
interface reg_write_arbiter_if;
  logic        WB_VALID;
  logic [4:0]  WB_ADDR;
  logic [31:0] WB_DATA;
  logic        MC_VALID;
  logic [4:0]  MC_ADDR;
  logic [31:0] MC_DATA;
  logic        MC_READY;
  logic        MC_ISSUE;
  logic [4:0]  MC_ISSUE_ADDR;
  logic [4:0]  ADDR1;
  logic [4:0]  ADDR2;
  logic        RS1_BUSY;
  logic        RS2_BUSY;
  logic        WR_EN;
  logic [4:0]  WR_ADDR;
  logic [31:0] WR_DATA;
  logic        STALL_REQ;

  modport master (
    output WB_VALID, WB_ADDR, WB_DATA, MC_VALID, MC_ADDR, MC_DATA,
           MC_ISSUE, MC_ISSUE_ADDR, ADDR1, ADDR2,
    input  MC_READY, RS1_BUSY, RS2_BUSY, WR_EN, WR_ADDR, WR_DATA, STALL_REQ
  );

  modport slave (
    input  WB_VALID, WB_ADDR, WB_DATA, MC_VALID, MC_ADDR, MC_DATA,
           MC_ISSUE, MC_ISSUE_ADDR, ADDR1, ADDR2,
    output MC_READY, RS1_BUSY, RS2_BUSY, WR_EN, WR_ADDR, WR_DATA, STALL_REQ
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Shares one register-file write port between the pipeline writeback and a
// buffered multicycle unit; tracks pending multicycle destinations.
module reg_write_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic              CLK,
  input logic              RST_N,
  reg_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

  logic [4:0]       fifo_addr [FIFO_DEPTH];
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] occ;
  logic [31:0]      busy;
  logic [31:0]      busy_nxt;
  logic [STV_W-1:0] starve_cnt;

  logic        empty;
  logic        full;
  logic        wb_req;
  logic        push;
  logic        pop;
  logic [4:0]  head_addr;
  logic [31:0] head_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  assign empty     = (occ == '0);
  assign full      = (occ == DEPTH_C);
  assign head_addr = fifo_addr[rd_ptr];
  assign head_data = fifo_data[rd_ptr];
  assign wb_req    = bus.WB_VALID && (bus.WB_ADDR != 5'd0);

  // The head only drains in cycles the pipeline leaves the port free.
  assign pop  = RST_N && !wb_req && !empty;
  assign push = bus.MC_VALID && bus.MC_READY && (bus.MC_ADDR != 5'd0);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = 5'd0;
    wr_data = 32'd0;
    if (RST_N && wb_req) begin
      wr_en   = 1'b1;
      wr_addr = bus.WB_ADDR;
      wr_data = bus.WB_DATA;
    end else if (pop) begin
      wr_en   = 1'b1;
      wr_addr = head_addr;
      wr_data = head_data;
    end
  end

  assign bus.WR_EN     = wr_en;
  assign bus.WR_ADDR   = wr_addr;
  assign bus.WR_DATA   = wr_data;
  assign bus.MC_READY  = RST_N && !full;
  assign bus.STALL_REQ = RST_N && ((starve_cnt >= LIMIT_C) || full);
  assign bus.RS1_BUSY  = RST_N && (bus.ADDR1 != 5'd0) && busy[bus.ADDR1];
  assign bus.RS2_BUSY  = RST_N && (bus.ADDR2 != 5'd0) && busy[bus.ADDR2];

  // Issue is applied after the pop clear so a same-address set survives.
  always_comb begin
    busy_nxt = busy;
    if (pop) begin
      busy_nxt[head_addr] = 1'b0;
    end
    if (bus.MC_ISSUE && (bus.MC_ISSUE_ADDR != 5'd0)) begin
      busy_nxt[bus.MC_ISSUE_ADDR] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.MC_ADDR;
      fifo_data[wr_ptr] <= bus.MC_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      occ        <= '0;
      busy       <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
      busy <= busy_nxt;
      // Saturates at the limit so a misbehaving pipeline keeps the stall up.
      if (empty || pop) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT_C) begin
        starve_cnt <= starve_cnt + STV_W'(1);
      end
    end
  end
endmodule
